// File: rtl/pipelined_rca_pkg.sv
// Shared helpers for the pipelined ripple-carry adder/subtractor.
package pipelined_rca_pkg;

   // Two's-complement overflow from the carries around the MSB.
   function automatic logic signed_ovf(input logic c_msb_in, input logic c_out);
      return c_msb_in ^ c_out;
   endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple chunks.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB
// so the last stage can derive signed overflow.
module rca_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   logic [CHUNK:0] carry_s;

   assign carry_s[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (carry_s[i]),
         .sum  (sum[i]),
         .cout (carry_s[i+1])
      );
   end

   assign cout     = carry_s[CHUNK];
   assign c_msb_in = carry_s[CHUNK-1];

endmodule

// File: rtl/pipelined_rca.sv
// Streaming WIDTH-bit adder/subtractor resolving CHUNK bits per pipeline stage,
// with a valid/ready handshake and a single global advance enable.
module pipelined_rca
   import pipelined_rca_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] A_i,
   input  logic [WIDTH-1:0] B_i,
   input  logic             Cin_i,
   input  logic             sub_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] Sum_o,
   output logic             Cout_o,
   output logic             Ovf_o
);

   localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
   localparam int STAGES     = WIDTH / CHUNK_SAFE;

   if ((CHUNK < 1) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_param_check
      $fatal(1, "pipelined_rca: WIDTH must be a positive multiple of CHUNK");
   end

   logic              adv_s;
   logic              xfer_s;
   logic [STAGES-1:0] valid_r;

   assign adv_s   = ~valid_o | ready_i;
   assign ready_o = adv_s;
   assign xfer_s  = valid_i & adv_s;

   // Stage valid bits shift together; bubbles are carried, not collapsed.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_r <= '0;
      end else if (adv_s) begin
         valid_r <= (valid_r << 1'b1) | STAGES'(xfer_s);
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int IW = WIDTH - k * CHUNK_SAFE;
      localparam int SW = (k + 1) * CHUNK_SAFE;

      logic [IW-1:0]         a_in_s;
      logic [IW-1:0]         b_in_s;
      logic                  c_in_s;
      logic                  load_s;
      logic [CHUNK_SAFE-1:0] sum_s;
      logic                  cout_s;
      logic                  c_msb_s;
      logic [SW-1:0]         sum_nxt_s;
      logic [SW-1:0]         sum_r;
      logic                  carry_r;

      // Stage 0 loads only on a real transfer, so idle inputs never enter the pipe.
      if (k == 0) begin : g_first
         assign a_in_s    = A_i;
         assign b_in_s    = sub_i ? ~B_i : B_i;
         assign c_in_s    = sub_i ? 1'b1 : Cin_i;
         assign load_s    = xfer_s;
         assign sum_nxt_s = sum_s;
      end else begin : g_next
         assign a_in_s    = g_stage[k-1].g_mid.a_rem_r;
         assign b_in_s    = g_stage[k-1].g_mid.b_rem_r;
         assign c_in_s    = g_stage[k-1].carry_r;
         assign load_s    = adv_s;
         assign sum_nxt_s = {sum_s, g_stage[k-1].sum_r};
      end

      rca_chunk #(.CHUNK(CHUNK_SAFE)) u_chunk (
         .a        (a_in_s[CHUNK_SAFE-1:0]),
         .b        (b_in_s[CHUNK_SAFE-1:0]),
         .cin      (c_in_s),
         .sum      (sum_s),
         .cout     (cout_s),
         .c_msb_in (c_msb_s)
      );

      // Accumulated low-order sum and the carry handed to the next slice.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            sum_r   <= '0;
            carry_r <= 1'b0;
         end else if (load_s) begin
            sum_r   <= sum_nxt_s;
            carry_r <= cout_s;
         end
      end

      if (k < STAGES - 1) begin : g_mid
         logic [IW-CHUNK_SAFE-1:0] a_rem_r;
         logic [IW-CHUNK_SAFE-1:0] b_rem_r;
         logic                     unused_msb_s;

         assign unused_msb_s = c_msb_s;

         // Operand bits not yet consumed travel with the partial result.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               a_rem_r <= '0;
               b_rem_r <= '0;
            end else if (load_s) begin
               a_rem_r <= a_in_s[IW-1:CHUNK_SAFE];
               b_rem_r <= b_in_s[IW-1:CHUNK_SAFE];
            end
         end
      end else begin : g_last
         logic ovf_r;

         // Overflow is resolved where the MSB carry is known.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               ovf_r <= 1'b0;
            end else if (load_s) begin
               ovf_r <= signed_ovf(c_msb_s, cout_s);
            end
         end
      end
   end

   assign valid_o = valid_r[STAGES-1];
   assign Sum_o   = g_stage[STAGES-1].sum_r;
   assign Cout_o  = g_stage[STAGES-1].carry_r;
   assign Ovf_o   = g_stage[STAGES-1].g_last.ovf_r;

endmodule
